// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the PWM register-bank arbiter.
// Holds the default bus widths, the grant FSM encoding and the m0 FIFO entry width.
package reg_bus_pkg;

  localparam int DEF_ADDR_W      = 6;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_M1_MAX_WAIT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2,
    ACK_M1 = 2'd3
  } state_e;

  // An m0 FIFO entry is packed as {we, addr, wdata}.
  function automatic int entry_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  localparam int DEF_ENTRY_W = entry_w(DEF_ADDR_W, DEF_DATA_W);

endpackage

// File: rtl/reg_req_fifo.sv
// Two-entry FIFO buffering SPI-decoder pulses; a push into a full FIFO is
// dropped and latches the sticky overflow flag unless a pop frees the slot.
module reg_req_fifo
  import reg_bus_pkg::*;
#(
  parameter int WIDTH = DEF_ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             overflow
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, push_ok, pop_ok;

  // NOTE: every signal assigned in always_comb gets a default first, and the
  // block uses blocking '=' only, so no latch is inferred.
  always_comb begin
    full       = (count_q == 2'd2);
    push_ok    = push && (!full || pop);
    pop_ok     = pop && (count_q != 2'd0);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push && !push_ok);

    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 2'd1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 2'd1;
    end
  end

  // NOTE: the payload storage has no reset; the count and pointers alone
  // define which entries are valid, so reset only has to clear those.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign dout     = mem_q[rd_ptr_q];
  assign empty    = (count_q == 2'd0);
  assign overflow = overflow_q;

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares the PWM register-bank port between the SPI decoder (buffered pulses)
// and a req/ack hardware agent, with a wait counter that bounds agent starvation.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int M1_MAX_WAIT = DEF_M1_MAX_WAIT,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bank_read,
  output logic              bank_write,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank_rdata,
  output logic              m0_overflow
);

  localparam int                ENTRY_W  = entry_w(ADDR_W, DATA_W);
  localparam int                WAIT_W   = $clog2(M1_MAX_WAIT + 2);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(M1_MAX_WAIT);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic [DATA_W-1:0]   hold_q, hold_d;

  logic                fifo_push, fifo_pop, fifo_empty;
  logic [ENTRY_W-1:0]  fifo_din, fifo_dout;
  logic                head_we;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_wdata;

  // A simultaneous read and write pulse is stored as a write.
  assign fifo_push = m0_read | m0_write;
  assign fifo_din  = {m0_write, m0_addr, (m0_write ? m0_wdata : {DATA_W{1'b0}})};
  assign fifo_pop  = (state_q == GNT_M0);

  assign head_we    = fifo_dout[ENTRY_W-1];
  assign head_addr  = fifo_dout[DATA_W +: ADDR_W];
  assign head_wdata = fifo_dout[DATA_W-1:0];

  reg_req_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .din      (fifo_din),
    .pop      (fifo_pop),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .overflow (m0_overflow)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    m1_rdata_d = m1_rdata_q;
    hold_d     = hold_q;
    bank_read  = 1'b0;
    bank_write = 1'b0;
    bank_addr  = m0_addr;
    bank_wdata = '0;
    m1_ack     = 1'b0;
    m0_rdata   = bank_rdata;

    if ((state_q == IDLE || state_q == GNT_M0) && m1_req && (wait_q < WAIT_MAX)) begin
      wait_d = wait_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (m1_req && (wait_q >= WAIT_MAX)) begin
          state_d = GNT_M1;
        end else if (!fifo_empty) begin
          state_d = GNT_M0;
        end else if (m1_req) begin
          state_d = GNT_M1;
        end
        if (state_d == GNT_M1) begin
          wait_d = '0;
        end
      end
      GNT_M0: begin
        bank_read  = !head_we;
        bank_write = head_we;
        bank_addr  = head_addr;
        bank_wdata = head_we ? head_wdata : '0;
        state_d    = IDLE;
      end
      GNT_M1: begin
        bank_read  = !m1_we;
        bank_write = m1_we;
        bank_addr  = m1_addr;
        bank_wdata = m1_we ? m1_wdata : '0;
        m1_rdata_d = bank_rdata;
        state_d    = ACK_M1;
      end
      ACK_M1: begin
        m1_ack  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The bank address belongs to a grant during strobes, so the decoder sees
    // the last value peeked before the strobe instead.
    if (bank_read || bank_write) begin
      m0_rdata = hold_q;
    end else begin
      hold_d = bank_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      m1_rdata_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      m1_rdata_q <= m1_rdata_d;
      hold_q     <= hold_d;
    end
  end

  assign m1_rdata = m1_rdata_q;

endmodule
